// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage: program counter and IF/ID register of the fetch stage.
// Parameters:
//   RESET_PC  - fetch address loaded on reset
//   NOP_INSTR - instruction word held in IF/ID while empty or flushed
// Ports:
//   clk, rst              - clock and synchronous active-high reset
//   PCASrc, PCBSrc        - redirect controls from the branch unit
//   ex_pc, ex_imm, ex_rs1 - operands of the EX-stage control transfer
//   stall                 - hazard-unit hold for PC and IF/ID
//   imem_addr/imem_rdata  - instruction memory port (combinational read)
//   if_id_pc/instr/valid  - IF/ID pipeline register
//   redirect              - taken control transfer this cycle (flushes ID/EX)
//   redirect_cnt          - redirect cycle counter (only with PERF_CNT_EN)
// Optional feature macro: PERF_CNT_EN adds the saturating redirect_cnt port.

module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCASrc,
    input  logic        PCBSrc,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    input  logic [31:0] ex_rs1,
    input  logic        stall,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        redirect
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] redirect_cnt
`endif
);

    // Word-aligned reset address keeps imem_addr[1:0] at zero even if
    // RESET_PC is given an unaligned value.
    localparam logic [31:0] RST_PC = {RESET_PC[31:2], 2'b00};

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    localparam if_id_t IF_ID_EMPTY = '{
        pc:    32'h0,
        instr: NOP_INSTR,
        valid: 1'b0
    };

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    if_id_t      if_id_q;
    if_id_t      if_id_d;

    logic [31:0] tgt_base;
    logic [31:0] tgt_add;
    logic [31:0] tgt_sum;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic        advance;

    // Redirect is suppressed during reset so downstream never flushes
    // on a stale branch decision while the pipeline is being cleared.
    assign redirect = ~rst & (PCASrc | PCBSrc);
    assign advance  = ~redirect & ~stall;

    assign tgt_base = PCBSrc ? ex_rs1 : ex_pc;
    assign tgt_add  = PCASrc ? ex_imm : 32'd4;
    assign tgt_sum  = tgt_base + tgt_add;
    assign target   = {tgt_sum[31:2], 2'b00};

    // Natural 32-bit wrap takes 32'hFFFF_FFFC back to zero.
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d    = pc_q;
        if_id_d = if_id_q;
        unique case (1'b1)
            redirect: begin
                pc_d    = target;
                if_id_d = IF_ID_EMPTY;
            end
            advance: begin
                pc_d          = pc_plus4;
                if_id_d.pc    = pc_q;
                if_id_d.instr = imem_rdata;
                if_id_d.valid = 1'b1;
            end
            default: begin
                pc_d    = pc_q;
                if_id_d = if_id_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RST_PC;
            if_id_q <= IF_ID_EMPTY;
        end else begin
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_pc    = if_id_q.pc;
    assign if_id_instr = if_id_q.instr;
    assign if_id_valid = if_id_q.valid;

`ifdef PERF_CNT_EN
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // Saturates rather than wrapping so long runs never under-report.
    always_comb begin
        cnt_d = cnt_q;
        if (redirect && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 32'h0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign redirect_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb_pc_fetch_stage: vector table, hand sequences and randomized
// checking of pc_fetch_stage against a behavioural model.

module tb_pc_fetch_stage;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] D   = 32'hDEAD_BEEF;
    localparam logic [31:0] I0  = 32'h00A0_0093;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCASrc;
    logic        PCBSrc;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] ex_rs1;
    logic        stall;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        redirect;
`ifdef PERF_CNT_EN
    logic [31:0] redirect_cnt;
`endif

    int total = 0;
    int bad   = 0;

    pc_fetch_stage #(
        .RESET_PC (RPC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .PCASrc     (PCASrc),
        .PCBSrc     (PCBSrc),
        .ex_pc      (ex_pc),
        .ex_imm     (ex_imm),
        .ex_rs1     (ex_rs1),
        .stall      (stall),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .if_id_pc   (if_id_pc),
        .if_id_instr(if_id_instr),
        .if_id_valid(if_id_valid),
        .redirect   (redirect)
`ifdef PERF_CNT_EN
        ,
        .redirect_cnt(redirect_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        a;
        logic        b;
        logic        stall;
        logic [31:0] epc;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] addr;
        logic [31:0] ipc;
        logic [31:0] instr;
        logic        valid;
    } vec_t;

    vec_t tbl[19];

    task automatic drive(input logic r, input logic a, input logic b,
                         input logic s, input logic [31:0] epc,
                         input logic [31:0] imm, input logic [31:0] rs1,
                         input logic [31:0] rd);
        rst        = r;
        PCASrc     = a;
        PCBSrc     = b;
        stall      = s;
        ex_pc      = epc;
        ex_imm     = imm;
        ex_rs1     = rs1;
        imem_rdata = rd;
    endtask

    logic [31:0] exp_cnt;
    logic [31:0] m_pc;
    logic [31:0] m_ipc;
    logic [31:0] m_ins;
    logic        m_v;

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, D, D, D, I0);
        exp_cnt = 32'h0;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, D, D, D, I0,
                    1'b0, 32'h0, 32'h0, NOP, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, D, D, D, I0,
                    1'b0, 32'h4, 32'h0, I0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, D, D, D, I0,
                    1'b0, 32'h8, 32'h4, I0, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, D, D, D, I0,
                    1'b0, 32'hC, 32'h8, I0, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'hFFFF_FFF0, D, I0,
                    1'b1, 32'h10, 32'h0, NOP, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, D, D, D, 32'h1111_1111,
                    1'b0, 32'h14, 32'h10, 32'h1111_1111, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, D, 32'h4, 32'h103, I0,
                    1'b1, 32'h104, 32'h0, NOP, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, D, D, D, 32'h2222_2222,
                    1'b0, 32'h108, 32'h104, 32'h2222_2222, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, D, D, 32'h39, I0,
                    1'b1, 32'h3C, 32'h0, NOP, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, D, D, D, 32'h3333_3333,
                    1'b0, 32'h40, 32'h3C, 32'h3333_3333, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, D, D, D, 32'h4444_4444,
                    1'b0, 32'h40, 32'h3C, 32'h3333_3333, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h1, 32'h2, 32'h3,
                    32'h4444_4444,
                    1'b0, 32'h40, 32'h3C, 32'h3333_3333, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h7C, 32'h4, D,
                    32'h4444_4444,
                    1'b1, 32'h80, 32'h0, NOP, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, D, D, D, 32'h5555_5555,
                    1'b0, 32'h84, 32'h80, 32'h5555_5555, 1'b1};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h4, D, I0,
                    1'b1, 32'hFFFF_FFFC, 32'h0, NOP, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, D, D, D, 32'h6666_6666,
                    1'b0, 32'h0, 32'hFFFF_FFFC, 32'h6666_6666, 1'b1};
        tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b0, D, D, 32'h200, I0,
                    1'b0, RPC, 32'h0, NOP, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b1, D, D, D, I0,
                    1'b0, RPC, 32'h0, NOP, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, D, D, D, 32'h7777_7777,
                    1'b0, RPC + 32'h4, RPC, 32'h7777_7777, 1'b1};

        @(posedge clk);
        #1;

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].rst, tbl[i].a, tbl[i].b, tbl[i].stall,
                  tbl[i].epc, tbl[i].imm, tbl[i].rs1, tbl[i].rdata);
            #1;
            chk($sformatf("v%0d redirect", i), 32'(redirect),
                32'(tbl[i].redir));
            if (tbl[i].rst) exp_cnt = 32'h0;
            else if (tbl[i].redir) exp_cnt = exp_cnt + 32'd1;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d imem_addr", i), imem_addr, tbl[i].addr);
            chk($sformatf("v%0d if_id_pc", i), if_id_pc, tbl[i].ipc);
            chk($sformatf("v%0d if_id_instr", i), if_id_instr,
                tbl[i].instr);
            chk($sformatf("v%0d if_id_valid", i), 32'(if_id_valid),
                32'(tbl[i].valid));
`ifdef PERF_CNT_EN
            chk($sformatf("v%0d redirect_cnt", i), redirect_cnt, exp_cnt);
`endif
        end

        // Five redirect cycles, the first under reset: four are counted.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h8, D, I0);
        @(posedge clk);
        #1;
        chk("rst_redirect addr", imem_addr, RPC);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h8, D, I0);
            #1;
            chk("seq redirect", 32'(redirect), 32'h1);
            @(posedge clk);
            #1;
            chk("seq addr", imem_addr, 32'h108);
        end
`ifdef PERF_CNT_EN
        chk("seq redirect_cnt", redirect_cnt, 32'd4);
`endif

        // Randomized phase against a behavioural model.
        m_pc    = RPC;
        m_ipc   = 32'h0;
        m_ins   = NOP;
        m_v     = 1'b0;
        exp_cnt = 32'h0;
        for (int n = 0; n < 400; n++) begin
            logic        r;
            logic        a;
            logic        b;
            logic        s;
            logic        er;
            logic [31:0] epc;
            logic [31:0] imm;
            logic [31:0] rs1;
            logic [31:0] rd;
            longint      t;
            r   = (n == 0) || ($urandom % 32 == 0);
            a   = ($urandom % 6 == 0);
            b   = ($urandom % 8 == 0);
            s   = ($urandom % 4 == 0);
            epc = $urandom;
            imm = $urandom;
            rs1 = $urandom;
            rd  = $urandom;
            drive(r, a, b, s, epc, imm, rs1, rd);
            er = !r && (a || b);
            #1;
            chk("rnd redirect", 32'(redirect), 32'(er));
            if (r) begin
                m_pc    = RPC;
                m_ipc   = 32'h0;
                m_ins   = NOP;
                m_v     = 1'b0;
                exp_cnt = 32'h0;
            end else if (er) begin
                t = (longint'(b ? rs1 : epc) + longint'(a ? imm : 32'd4))
                    % 64'h1_0000_0000;
                t = t - (t % 4);
                m_pc  = 32'(t);
                m_ipc = 32'h0;
                m_ins = NOP;
                m_v   = 1'b0;
                if (exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
            end else if (!s) begin
                m_ipc = m_pc;
                m_ins = rd;
                m_v   = 1'b1;
                m_pc  = 32'((longint'(m_pc) + 4) % 64'h1_0000_0000);
            end
            @(posedge clk);
            #1;
            chk("rnd imem_addr", imem_addr, m_pc);
            chk("rnd addr_align", 32'(imem_addr[1:0]), 32'h0);
            chk("rnd if_id_pc", if_id_pc, m_ipc);
            chk("rnd if_id_instr", if_id_instr, m_ins);
            chk("rnd if_id_valid", 32'(if_id_valid), 32'(m_v));
`ifdef PERF_CNT_EN
            chk("rnd redirect_cnt", redirect_cnt, exp_cnt);
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_stage.md
PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the fetch address loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, the instruction word placed in IF/ID when empty or flushed.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 PCASrc  input  1  from branch control: 1 selects ex_imm as the addend, 0 selects constant 4.
REQ-006 PCBSrc  input  1  from branch control: 1 selects ex_rs1 as the base, 0 selects ex_pc.
REQ-007 ex_pc  input  32  PC of the instruction in EX.
REQ-008 ex_imm  input  32  sign-extended immediate of the instruction in EX.
REQ-009 ex_rs1  input  32  forwarded rs1 value of the instruction in EX.
REQ-010 stall  input  1  hazard-unit hold request for the PC and IF/ID.
REQ-011 imem_addr  output  32  instruction memory address, equal to the current PC register.
REQ-012 imem_rdata  input  32  instruction word returned combinationally for imem_addr.
REQ-013 if_id_pc  output  32  registered PC of the fetched instruction.
REQ-014 if_id_instr  output  32  registered fetched instruction.
REQ-015 if_id_valid  output  1  1 when IF/ID holds a real instruction.
REQ-016 redirect  output  1  combinational: PCASrc OR PCBSrc, forced 0 while rst=1; used downstream to flush ID/EX.
REQ-017 redirect_cnt  output  32  count of redirect cycles; this port exists only under PERF_CNT_EN.

Function
REQ-018 The target SHALL be (PCBSrc ? ex_rs1 : ex_pc) + (PCASrc ? ex_imm : 32'd4), computed modulo 2^32, with bits [1:0] forced to 00.
REQ-019 Priority per cycle SHALL be: rst, then redirect, then stall, then normal advance.
REQ-020 On redirect: PC <= target; if_id_valid <= 0; if_id_instr <= NOP_INSTR; if_id_pc <= 0.
REQ-021 Redirect SHALL override stall in the same cycle, so the wrong-path instruction held by the stall is discarded.
REQ-022 On stall without redirect: PC, if_id_pc, if_id_instr and if_id_valid SHALL hold their values.
REQ-023 On normal advance: PC <= PC+4 (wrapping 32'hFFFF_FFFC to 32'h0000_0000); if_id_pc <= PC; if_id_instr <= imem_rdata; if_id_valid <= 1.
REQ-024 Fetch-to-IF/ID latency SHALL be 1 cycle; redirect-to-target fetch latency SHALL be 1 cycle (imem_addr equals the target in the cycle after redirect).
REQ-025 With PCASrc=PCBSrc=0, the PC path SHALL be unaffected by ex_pc, ex_imm and ex_rs1.
REQ-026 imem_addr SHALL never be driven with non-zero bits [1:0].

Reset
REQ-027 With rst=1 at a rising edge: PC <= RESET_PC; if_id_pc <= 0; if_id_instr <= NOP_INSTR; if_id_valid <= 0; redirect_cnt <= 0.
REQ-028 rst SHALL override a simultaneous redirect or stall, including a reset asserted mid-redirect.
REQ-029 In the first cycle after rst deasserts, imem_addr SHALL be RESET_PC; if_id_valid SHALL rise at the following edge unless stall or redirect is asserted.

Configuration
REQ-030 Macro PERF_CNT_EN defined: redirect_cnt is present; it increments by 1 on each rising edge where redirect=1 and rst=0, and saturates at 32'hFFFF_FFFF.
REQ-031 Macro PERF_CNT_EN undefined: the redirect_cnt port and its counter are absent; all other behaviour is identical.

Verification
REQ-032 Reset, then 3 cycles with no stall and no redirect, imem_rdata=32'h00A00093 -> imem_addr sequence 0, 4, 8, 12; if_id_pc 0, 4, 8; if_id_valid=1 from the 2nd edge.
REQ-033 Branch: ex_pc=32'h20, ex_imm=32'hFFFF_FFF0, PCASrc=1, PCBSrc=0 -> next imem_addr=32'h10; if_id_valid=0 and if_id_instr=32'h13 for 1 cycle.
REQ-034 JALR: ex_rs1=32'h103, ex_imm=4, PCASrc=1, PCBSrc=1 -> next imem_addr=32'h104; redirect=1 for exactly that cycle.
REQ-035 Stall for 2 cycles at PC=32'h40 -> imem_addr stays 32'h40 and IF/ID unchanged; stall and redirect together (target 32'h80) -> imem_addr=32'h80 and IF/ID flushed.
REQ-036 PC=32'hFFFF_FFFC with normal advance -> imem_addr=0; rst asserted during a redirect -> imem_addr=RESET_PC and redirect_cnt=0.
REQ-037 Under PERF_CNT_EN: 5 redirect cycles, 1 of them with rst=1 -> redirect_cnt=4.
